// File: rtl/dac_serializador.sv
// Converts a signed filter sample back to a 12-bit DAC code and shifts it out as a 16-bit SPI frame.
// Optional macro DAC_ROUND_EN: round half-up instead of truncating when dropping the fractional LSBs.
module dac_serializador #(
   parameter int N       = 23,
   parameter int N_DAC   = 12,
   parameter int OFFSET  = 8192,
   parameter int FRAC_SH = 2,
   parameter int CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     Salida_Filtros,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             sat,
   output logic [N_DAC-1:0] dac_code,
   output logic             sclk,
   output logic             sync_n,
   output logic             sdata
);

   localparam int FW    = 16;
   localparam int SW    = N + 2;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
`ifdef DAC_ROUND_EN
   localparam int ROUND = (FRAC_SH > 0) ? (1 << (FRAC_SH - 1)) : 0;
`endif

   // bit 0 = frame active (drives sync_n), bit 1 = end-of-frame (drives done)
   typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, FIN = 2'b10} state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [4:0]         hp_q, hp_d;
   logic               sclk_q, sclk_d;
   logic [FW-1:0]      sh_q, sh_d;
   logic [N_DAC-1:0]   code_q, code_d;
   logic               sat_q, sat_d;

   logic signed [SW-1:0] s_ext, q;
   logic [N_DAC-1:0]     code_new;
   logic                 sat_new;

   always_comb begin
      s_ext = {{2{Salida_Filtros[N-1]}}, Salida_Filtros} + SW'(OFFSET);
`ifdef DAC_ROUND_EN
      s_ext = s_ext + SW'(ROUND);
`endif
      q        = s_ext >>> FRAC_SH;
      code_new = q[N_DAC-1:0];
      sat_new  = 1'b0;
      if (q[SW-1]) begin
         code_new = '0;
         sat_new  = 1'b1;
      end else if (|q[SW-2:N_DAC]) begin
         code_new = '1;
         sat_new  = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      hp_d    = hp_q;
      sclk_d  = sclk_q;
      sh_d    = sh_q;
      code_d  = code_q;
      sat_d   = sat_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               code_d  = code_new;
               sat_d   = sat_new;
               sh_d    = {{(FW-N_DAC){1'b0}}, code_new};
               div_d   = '0;
               hp_d    = '0;
               sclk_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               hp_d   = hp_q + 5'd1;
               // data advances on rising sclk so it is stable across the DAC's falling-edge sample
               if (!sclk_q) sh_d = {sh_q[FW-2:0], 1'b0};
               if (hp_q == 5'd31) state_d = FIN;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         hp_q    <= '0;
         sclk_q  <= 1'b1;
         sh_q    <= '0;
         code_q  <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         hp_q    <= hp_d;
         sclk_q  <= sclk_d;
         sh_q    <= sh_d;
         code_q  <= code_d;
         sat_q   <= sat_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign sync_n   = ~state_q[0];
   assign done     = state_q[1];
   assign sdata    = state_q[0] & sh_q[FW-1];
   assign sclk     = sclk_q;
   assign dac_code = code_q;
   assign sat      = sat_q;

endmodule
